// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_pkg
//  Purpose : Shared types and constants for the 8-bit core sequencer:
//            FSM state encoding, ctrl_flags bit positions, write-back source
//            select encoding and the illegal opcode values.
//  Rev     : 1.0  initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F_HI = 3'd1,
        ST_F_LO = 3'd2,
        ST_DEC  = 3'd3,
        ST_EXEC = 3'd4,
        ST_MEM  = 3'd5
    } state_t;

    // Bit positions inside the decode ROM's ctrl_flags byte
    localparam int c_cf_br   = 7;
    localparam int c_cf_imm  = 6;
    localparam int c_cf_jimm = 5;
    localparam int c_cf_jreg = 4;
    localparam int c_cf_link = 3;
    localparam int c_cf_mw   = 2;
    localparam int c_cf_mr   = 1;
    localparam int c_cf_ldi  = 0;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_IMM = 2'd2,
        WB_PC  = 2'd3
    } wb_src_t;

    localparam logic [3:0] c_op_illegal_a = 4'hA;
    localparam logic [3:0] c_op_illegal_b = 4'hB;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == c_op_illegal_a) || (op == c_op_illegal_b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module  : bus_wait_timer
//  Purpose : Counts consecutive cycles in which a bus request is pending
//            without mem_ready and flags a timeout on the WAIT_MAX-th such
//            cycle. WAIT_MAX = 0 disables the timeout entirely.
//  Ports   : clk, rst       clock / synchronous active-high reset
//            i_req          bus request currently asserted
//            i_ready        bus completes the access this cycle
//            o_timeout      this wait cycle is the WAIT_MAX-th; abandon access
//  Rev     : 1.0  initial release
// ============================================================================
module bus_wait_timer #(
    parameter int WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_ready,
    output logic o_timeout
);

    generate
        if (WAIT_MAX == 0) begin : g_disabled
            assign o_timeout = 1'b0;
        end else begin : g_enabled
            localparam int c_cw = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
            // Counter holds completed wait cycles, so the last one is WAIT_MAX-1
            localparam logic [c_cw-1:0] c_last = c_cw'(WAIT_MAX - 1);

            logic [c_cw-1:0] r_count;
            logic            w_wait;

            assign w_wait    = i_req & ~i_ready;
            assign o_timeout = w_wait && (r_count == c_last);

            always_ff @(posedge clk) begin
                if (rst || !w_wait || o_timeout) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_sequencer
//  Purpose : Multi-cycle control FSM of the 8-bit core. Fetches a 16-bit
//            instruction as two bytes, turns decode ROM flags into datapath
//            strobes and shares the single memory port between fetch and
//            load/store.
//  Ports   : clk, rst, run            clock, sync reset, run/stop request
//            opcode, alu_flags,       decode inputs (ir[15:12] and ROM)
//            ctrl_flags, br_cond
//            mem_ready / mem_req,     memory handshake and address select
//            mem_we, mem_addr_sel
//            ir_hi_we, ir_lo_we,      IR / PC strobes
//            pc_inc, pc_load, pc_src
//            alu_b_imm, alu_ctrl      ALU operand select and latched flags
//            reg_we, wb_src           register-file write strobe and source
//            illegal, bus_err, busy,  status
//            retired
//  Rev     : 1.0  initial release
// ============================================================================
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int RET_W    = 16,
    parameter int WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic [7:0]       alu_flags,
    input  logic [7:0]       ctrl_flags,
    input  logic             br_cond,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_hi_we,
    output logic             ir_lo_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             pc_src,
    output logic             alu_b_imm,
    output logic [7:0]       alu_ctrl,
    output logic             reg_we,
    output logic [1:0]       wb_src,
    output logic             illegal,
    output logic             bus_err,
    output logic             busy,
    output logic [RET_W-1:0] retired
);

    state_t           r_state;
    state_t           w_state_nxt;
    state_t           w_boundary;
    logic [7:0]       r_ctrl;
    logic [7:0]       w_cf;
    logic             w_timeout;
    logic             w_illegal_op;
    logic             w_ldi, w_mem_op, w_jump, w_br, w_alu;
    logic             w_retire;

    logic             r_mem_req, r_mem_we, r_addr_sel, r_alu_b_imm;
    logic             r_exec_we, r_pc_load, r_pc_src, r_illegal, r_busy, r_bus_err;
    wb_src_t          r_wb_src;
    logic [7:0]       r_alu_ctrl;
    logic [RET_W-1:0] r_retired;

    bus_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_req     (r_mem_req),
        .i_ready   (mem_ready),
        .o_timeout (w_timeout)
    );

    // While in DEC the ROM output is live; afterwards the latched copy holds
    // the instruction's flags even if the ROM input starts changing.
    assign w_cf         = (r_state == ST_DEC) ? ctrl_flags : r_ctrl;
    assign w_illegal_op = is_illegal(opcode);

    // Instruction class, in priority order
    assign w_ldi    = w_cf[c_cf_ldi];
    assign w_mem_op = !w_ldi && (w_cf[c_cf_mr] || w_cf[c_cf_mw]);
    assign w_jump   = !w_ldi && !w_mem_op && (w_cf[c_cf_jimm] || w_cf[c_cf_jreg]);
    assign w_br     = !w_ldi && !w_mem_op && !w_jump && w_cf[c_cf_br];
    assign w_alu    = !w_ldi && !w_mem_op && !w_jump && !w_br;

    assign w_boundary = run ? ST_F_HI : ST_IDLE;

    assign w_retire = ((r_state == ST_DEC)  && w_illegal_op) ||
                      ((r_state == ST_EXEC) && !w_mem_op)    ||
                      ((r_state == ST_MEM)  && mem_ready);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (run) w_state_nxt = ST_F_HI;
            ST_F_HI: begin
                if (w_timeout)      w_state_nxt = ST_IDLE;
                else if (mem_ready) w_state_nxt = ST_F_LO;
            end
            ST_F_LO: begin
                if (w_timeout)      w_state_nxt = ST_IDLE;
                else if (mem_ready) w_state_nxt = ST_DEC;
            end
            ST_DEC:  w_state_nxt = w_illegal_op ? w_boundary : ST_EXEC;
            ST_EXEC: w_state_nxt = w_mem_op ? ST_MEM : w_boundary;
            ST_MEM: begin
                if (w_timeout)      w_state_nxt = ST_IDLE;
                else if (mem_ready) w_state_nxt = w_boundary;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State plus all state-level outputs, registered from the next state so
    // each strobe is valid for the whole cycle of the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ctrl      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_addr_sel  <= 1'b0;
            r_alu_b_imm <= 1'b0;
            r_exec_we   <= 1'b0;
            r_pc_load   <= 1'b0;
            r_pc_src    <= 1'b0;
            r_wb_src    <= WB_ALU;
            r_illegal   <= 1'b0;
            r_busy      <= 1'b0;
            r_bus_err   <= 1'b0;
            r_alu_ctrl  <= '0;
            r_retired   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= (w_state_nxt inside {ST_F_HI, ST_F_LO, ST_MEM});
            r_addr_sel  <= (w_state_nxt == ST_MEM);
            r_mem_we    <= (w_state_nxt == ST_MEM) && w_cf[c_cf_mw];
            // Immediate operand held through MEM: the ALU forms the address
            r_alu_b_imm <= (w_state_nxt inside {ST_EXEC, ST_MEM}) && w_cf[c_cf_imm];
            r_exec_we   <= (w_state_nxt == ST_EXEC) &&
                           (w_ldi || (w_jump && w_cf[c_cf_link]) || w_alu);
            r_pc_load   <= (w_state_nxt == ST_EXEC) && (w_jump || (w_br && br_cond));
            r_pc_src    <= (w_state_nxt == ST_EXEC) && w_jump && w_cf[c_cf_jreg];
            r_illegal   <= (w_state_nxt == ST_DEC) && w_illegal_op;
            r_busy      <= (w_state_nxt != ST_IDLE);

            if (w_state_nxt == ST_EXEC) begin
                if (w_ldi)                         r_wb_src <= WB_IMM;
                else if (w_jump && w_cf[c_cf_link]) r_wb_src <= WB_PC;
                else                               r_wb_src <= WB_ALU;
            end else if ((w_state_nxt == ST_MEM) && w_cf[c_cf_mr]) begin
                r_wb_src <= WB_MEM;
            end else begin
                r_wb_src <= WB_ALU;
            end

            if (r_state == ST_DEC) begin
                r_alu_ctrl <= alu_flags;
                r_ctrl     <= ctrl_flags;
            end
            if (w_retire)  r_retired <= r_retired + RET_W'(1);
            if (w_timeout) r_bus_err <= 1'b1;
        end
    end

    // Bus-completion strobes must coincide with the ready cycle, when read
    // data is valid, so they are qualified by mem_ready directly.
    assign ir_hi_we = (r_state == ST_F_HI) && mem_ready;
    assign ir_lo_we = (r_state == ST_F_LO) && mem_ready;
    assign pc_inc   = ir_hi_we || ir_lo_we;
    assign reg_we   = r_exec_we || ((r_state == ST_MEM) && r_ctrl[c_cf_mr] && mem_ready);

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr_sel = r_addr_sel;
    assign pc_load      = r_pc_load;
    assign pc_src       = r_pc_src;
    assign alu_b_imm    = r_alu_b_imm;
    assign alu_ctrl     = r_alu_ctrl;
    assign wb_src       = r_wb_src;
    assign illegal      = r_illegal;
    assign bus_err      = r_bus_err;
    assign busy         = r_busy;
    assign retired      = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_cpu_sequencer
//  Purpose : Directed self-checking bench for cpu_sequencer: reset, ALU op,
//            load with wait states, branch taken / not taken, illegal opcode,
//            bus timeout and reset during a store.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic [3:0]  opcode;
    logic [7:0]  alu_flags;
    logic [7:0]  ctrl_flags;
    logic        br_cond;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel;
    logic        ir_hi_we, ir_lo_we, pc_inc, pc_load, pc_src, alu_b_imm;
    logic [7:0]  alu_ctrl;
    logic        reg_we;
    logic [1:0]  wb_src;
    logic        illegal, bus_err, busy;
    logic [15:0] retired;

    int n_cmp = 0;
    int n_err = 0;

    cpu_sequencer #(
        .RET_W    (16),
        .WAIT_MAX (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .opcode       (opcode),
        .alu_flags    (alu_flags),
        .ctrl_flags   (ctrl_flags),
        .br_cond      (br_cond),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_hi_we     (ir_hi_we),
        .ir_lo_we     (ir_lo_we),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .pc_src       (pc_src),
        .alu_b_imm    (alu_b_imm),
        .alu_ctrl     (alu_ctrl),
        .reg_we       (reg_we),
        .wb_src       (wb_src),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .busy         (busy),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; opcode = 4'h0; alu_flags = 8'h00;
        ctrl_flags = 8'h00; br_cond = 1'b0; mem_ready = 1'b0;
        repeat (2) tick();

        // ---- reset state
        check_val("rst_strobes",
                  {mem_req, mem_we, mem_addr_sel, ir_hi_we, ir_lo_we, pc_inc, pc_load,
                   pc_src, alu_b_imm, reg_we, wb_src, illegal, bus_err, busy}, 32'h0);
        check_val("rst_alu_ctrl", alu_ctrl, 32'h0);
        check_val("rst_retired", retired, 32'h0);

        // ---- add (op 0), zero wait: F_HI F_LO DEC EXEC
        rst = 1'b0; run = 1'b1; mem_ready = 1'b1;
        tick();
        check_val("add_fhi_req_sel", {mem_req, mem_addr_sel, busy}, 3'b101);
        check_val("add_fhi_strb", {ir_hi_we, ir_lo_we, pc_inc}, 3'b101);
        tick();
        check_val("add_flo", {mem_req, ir_hi_we, ir_lo_we, pc_inc}, 4'b1011);
        tick();
        check_val("add_dec", {mem_req, reg_we, illegal, busy}, 4'b0001);
        tick();
        check_val("add_exec", {reg_we, wb_src, pc_load, mem_req}, {1'b1, 2'd0, 1'b0, 1'b0});
        check_val("add_alu_ctrl", alu_ctrl, 32'h00);
        check_val("add_ret_before", retired, 32'd0);
        run = 1'b0;
        tick();
        check_val("add_ret_after", retired, 32'd1);
        check_val("add_idle", {busy, reg_we, mem_req}, 3'b000);

        // ---- ldb (op E): 3 wait cycles in MEM
        opcode = 4'hE; ctrl_flags = 8'h42; alu_flags = 8'h81; run = 1'b1; mem_ready = 1'b1;
        repeat (4) tick();
        check_val("ldb_exec", {reg_we, mem_req, alu_b_imm}, 3'b001);
        check_val("ldb_alu_ctrl", alu_ctrl, 32'h81);
        mem_ready = 1'b0;
        tick();
        check_val("ldb_mem1", {mem_req, mem_addr_sel, mem_we, reg_we}, 4'b1100);
        check_val("ldb_mem1_wb", wb_src, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("ldb_wait", {mem_req, mem_addr_sel, reg_we}, 3'b110);
        end
        mem_ready = 1'b1;
        #1;
        check_val("ldb_ready", {reg_we, wb_src, mem_addr_sel}, {1'b1, 2'd1, 1'b1});
        run = 1'b0;
        tick();
        check_val("ldb_ret", retired, 32'd2);
        check_val("ldb_idle", {busy, reg_we, mem_req}, 3'b000);

        // ---- b-- (op 9): taken, then not taken back-to-back
        opcode = 4'h9; ctrl_flags = 8'h80; alu_flags = 8'h5A; br_cond = 1'b1; run = 1'b1;
        repeat (4) tick();
        check_val("br_taken", {pc_load, pc_src, reg_we}, 3'b100);
        check_val("br_alu_ctrl", alu_ctrl, 32'h5A);
        br_cond = 1'b0;
        tick();
        check_val("br_ret1", retired, 32'd3);
        check_val("br_refetch", mem_req, 32'd1);
        repeat (3) tick();
        check_val("br_not_taken", {pc_load, reg_we}, 2'b00);
        run = 1'b0;
        tick();
        check_val("br_ret2", retired, 32'd4);

        // ---- illegal opcode B
        opcode = 4'hB; ctrl_flags = 8'h00; run = 1'b1;
        tick();
        tick();
        check_val("ill_pre", {illegal, reg_we}, 2'b00);
        run = 1'b0;
        tick();
        check_val("ill_dec", {illegal, reg_we, mem_req, busy}, 4'b1001);
        tick();
        check_val("ill_after", {illegal, reg_we, mem_req, busy}, 4'b0000);
        check_val("ill_ret", retired, 32'd5);

        // ---- timeout: mem_ready stuck low during fetch, WAIT_MAX = 4
        opcode = 4'h0; mem_ready = 1'b0; run = 1'b1;
        tick();
        check_val("to_w1", {mem_req, bus_err}, 2'b10);
        tick();
        tick();
        run = 1'b0;
        tick();
        check_val("to_w4", {mem_req, bus_err, busy}, 3'b101);
        tick();
        check_val("to_err", {bus_err, mem_req, busy}, 3'b100);
        check_val("to_no_retire", retired, 32'd5);

        // ---- reset during a store data phase
        opcode = 4'hF; ctrl_flags = 8'h44; mem_ready = 1'b1; run = 1'b1;
        repeat (4) tick();
        mem_ready = 1'b0;
        tick();
        check_val("stb_mem", {mem_req, mem_we, mem_addr_sel, alu_b_imm, bus_err}, 5'b11111);
        rst = 1'b1;
        tick();
        check_val("stb_rst", {mem_req, mem_we, busy, bus_err, reg_we}, 5'b00000);
        check_val("stb_rst_ret", retired, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
